// File: rtl/dfe_sched_pkg.sv
// dfe_sched_pkg
// Shared types and defaults for the DFE rate-enable scheduler.
//   sched_state_t : scheduler FSM states
//   DEF_CNT_W     : default width of pulse count, cycle count and period index
//   ratio_t       : a P/M pacing ratio at the default width
package dfe_sched_pkg;

  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] pulses;
    logic [DEF_CNT_W-1:0] cycles;
  } ratio_t;

endpackage

// File: rtl/frac_accum.sv
// frac_accum
// Bresenham accumulator that decides whether the cycle being entered carries
// an enable pulse. The decision is registered, so `pulse` is valid during the
// cycle it belongs to.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   advance   : a scheduled cycle is being entered at this edge
//   clear     : the cycle being entered is period index 0
//   p, m      : ratio in force for the cycle being entered (p <= m, m >= 1)
//   pulse     : registered enable for the current cycle
module frac_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             clear,
  input  logic [CNT_W-1:0] p,
  input  logic [CNT_W-1:0] m,
  output logic             pulse
);

  // One extra bit: residue < m plus p <= m never exceeds 2*m - 1.
  logic [CNT_W:0] acc;
  logic [CNT_W:0] base;
  logic [CNT_W:0] sum;
  logic           hit;

  // NOTE: every combinational output is assigned on every path, so no latch is inferred.
  always_comb begin
    base = clear ? '0 : acc;
    sum  = base + {1'b0, p};
    hit  = (sum >= {1'b0, m});
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      pulse <= 1'b0;
    end else if (advance) begin
      pulse <= hit;
      acc   <= hit ? (sum - {1'b0, m}) : sum;
    end else begin
      pulse <= 1'b0;
      acc   <= '0;
    end
  end

endmodule

// File: rtl/rate_enable_scheduler.sv
// rate_enable_scheduler
// Emits P evenly spread single-cycle clk_enable pulses per M-cycle period for
// the DFE filter stages. The ratio is reprogrammed through a valid/ready port
// into a shadow register and only takes effect on a period boundary (or at
// once while idle). Stop requests finish the current period before idling.
// Optional statistics are compiled in with `define RATE_SCHED_STATS_EN.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, stop           : level-sampled run / stop requests
//   cfg_valid, cfg_ready  : ratio handshake (cfg_ready registered)
//   cfg_pulses, cfg_cycles: requested P and M
//   cfg_err               : one-cycle pulse after an illegal ratio was consumed
//   clk_enable            : paced enable
//   period_start          : high during period index 0
//   busy                  : scheduler not idle
//   period_count          : (stats) saturating count of completed periods
//   pulse_mismatch        : (stats) sticky, a period's pulse count differed from P
module rate_enable_scheduler
  import dfe_sched_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEF_PULSES = 1,
  parameter int DEF_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_pulses,
  input  logic [CNT_W-1:0] cfg_cycles,
  output logic             cfg_err,
  output logic             clk_enable,
  output logic             period_start,
  output logic             busy
`ifdef RATE_SCHED_STATS_EN
  ,
  output logic [15:0]      period_count,
  output logic             pulse_mismatch
`endif
);

  sched_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] act_p, act_m;
  logic [CNT_W-1:0] shd_p, shd_m;
  logic             pend, pend_n;
  logic             xfer, cfg_bad, last, wrap, apply;
  logic [CNT_W-1:0] nxt_p, nxt_m;

  always_comb begin
    xfer    = cfg_valid && cfg_ready;
    cfg_bad = (cfg_cycles == '0) || (cfg_pulses > cfg_cycles);
    last    = (cnt == act_m - CNT_W'(1));
    wrap    = (state != IDLE) && last;
    // Shadow lands immediately when idle, otherwise only on the period wrap.
    apply   = pend && ((state == IDLE) || last);
    nxt_p   = apply ? shd_p : act_p;
    nxt_m   = apply ? shd_m : act_m;

    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        if (last) begin
          state_n = stop ? IDLE : RUN;
          cnt_n   = '0;
        end else begin
          state_n = stop ? DRAIN : RUN;
          cnt_n   = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (last) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    pend_n = apply ? 1'b0 : pend;
    if (xfer && !cfg_bad) pend_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      act_p        <= CNT_W'(DEF_PULSES);
      act_m        <= CNT_W'(DEF_CYCLES);
      // NOTE: the shadow is cleared on reset too, so a dropped config can never resurface.
      shd_p        <= '0;
      shd_m        <= '0;
      pend         <= 1'b0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      period_start <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      if (apply) begin
        act_p <= shd_p;
        act_m <= shd_m;
      end
      if (xfer && !cfg_bad) begin
        shd_p <= cfg_pulses;
        shd_m <= cfg_cycles;
      end
      pend         <= pend_n;
      // Any transfer drops ready for at least one cycle; it stays low while pending.
      cfg_ready    <= !pend_n && !xfer;
      cfg_err      <= xfer && cfg_bad;
      period_start <= (state_n != IDLE) && (cnt_n == '0);
      busy         <= (state_n != IDLE);
    end
  end

  // The pulse decision for the cycle being entered uses the ratio that will
  // be active in that cycle, including a freshly applied shadow at c = 0.
  frac_accum #(.CNT_W(CNT_W)) u_accum (
    .clk     (clk),
    .rst     (rst),
    .advance (state_n != IDLE),
    .clear   (cnt_n == '0),
    .p       (nxt_p),
    .m       (nxt_m),
    .pulse   (clk_enable)
  );

`ifdef RATE_SCHED_STATS_EN
  logic [CNT_W:0] pcnt;
  logic [CNT_W:0] pcnt_tot;

  always_comb pcnt_tot = pcnt + (CNT_W+1)'(clk_enable);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt           <= '0;
      period_count   <= '0;
      pulse_mismatch <= 1'b0;
    end else if (wrap) begin
      pcnt <= '0;
      if (period_count != 16'hFFFF) period_count <= period_count + 16'd1;
      if (pcnt_tot != {1'b0, act_p}) pulse_mismatch <= 1'b1;
    end else if (state != IDLE) begin
      pcnt <= pcnt_tot;
    end
  end
`endif

endmodule

// File: tb/tb_rate_enable_scheduler.sv
// tb_rate_enable_scheduler
// Directed scenarios with literal expectations, followed by randomized
// start/stop/config/reset traffic compared every cycle against a ratio-level
// model that derives clk_enable from floor((c+1)P/M) > floor(cP/M).
module tb_rate_enable_scheduler;
  import dfe_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, stop, cfg_valid;
  logic [7:0] cfg_pulses, cfg_cycles;
  logic       cfg_ready, cfg_err, clk_enable, period_start, busy;
`ifdef RATE_SCHED_STATS_EN
  logic [15:0] period_count;
  logic        pulse_mismatch;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rate_enable_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_pulses   (cfg_pulses),
    .cfg_cycles   (cfg_cycles),
    .cfg_err      (cfg_err),
    .clk_enable   (clk_enable),
    .period_start (period_start),
    .busy         (busy)
`ifdef RATE_SCHED_STATS_EN
    ,
    .period_count   (period_count),
    .pulse_mismatch (pulse_mismatch)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  ratio_t m_act, m_shd;
  bit     m_busy, m_drain, m_pend, m_ready;
  int     m_c, m_periods;
  bit     exp_en, exp_ps, exp_busy, exp_err, exp_ready;
  bit     model_on = 1'b0;

  always @(posedge clk) begin
    bit xfer, bad, last, apply;
    model_on = 1'b1;
    if (rst) begin
      m_act   = '{pulses: 8'd1, cycles: 8'd2};
      m_shd   = '0;
      m_busy  = 1'b0;
      m_drain = 1'b0;
      m_pend  = 1'b0;
      m_ready = 1'b1;
      m_c     = 0;
      m_periods = 0;
      exp_err = 1'b0;
    end else begin
      xfer  = cfg_valid && m_ready;
      bad   = (cfg_cycles == 0) || (cfg_pulses > cfg_cycles);
      last  = m_busy && (m_c == int'(m_act.cycles) - 1);
      apply = m_pend && (!m_busy || last);
      if (last && m_periods < 65535) m_periods++;
      if (m_busy) begin
        if (last) begin
          if (m_drain || stop) begin
            m_busy  = 1'b0;
            m_drain = 1'b0;
          end
          m_c = 0;
        end else begin
          m_c++;
          if (stop) m_drain = 1'b1;
        end
      end else if (start && !stop) begin
        m_busy = 1'b1;
        m_c    = 0;
      end
      if (apply) begin
        m_act  = m_shd;
        m_pend = 1'b0;
      end
      if (xfer && !bad) begin
        m_shd  = '{pulses: cfg_pulses, cycles: cfg_cycles};
        m_pend = 1'b1;
      end
      exp_err = xfer && bad;
      m_ready = !m_pend && !xfer;
    end
    exp_ready = m_ready;
    exp_busy  = m_busy;
    exp_ps    = m_busy && (m_c == 0);
    exp_en    = m_busy &&
                (((m_c + 1) * int'(m_act.pulses)) / int'(m_act.cycles) >
                 (m_c * int'(m_act.pulses)) / int'(m_act.cycles));
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_clk_enable", clk_enable, exp_en);
      check("m_period_start", period_start, exp_ps);
      check("m_busy", busy, exp_busy);
      check("m_cfg_ready", cfg_ready, exp_ready);
      check("m_cfg_err", cfg_err, exp_err);
`ifdef RATE_SCHED_STATS_EN
      check("m_period_count", period_count, m_periods);
      check("m_pulse_mismatch", pulse_mismatch, 0);
`endif
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ps(input string name, input int max);
    int n = 0;
    @(negedge clk);
    while (!period_start && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, period_start, 1);
  endtask

  task automatic capture8(output logic [7:0] pat);
    pat[0] = clk_enable;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      pat[c] = clk_enable;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clk_enable"}, clk_enable, 0);
    check({tag, "_period_start"}, period_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_pulses = '0; cfg_cycles = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Default 1/2 ratio.
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("default_en", clk_enable, i % 2);
      check("default_ps", period_start, (i % 2) == 0);
    end

    // Reprogram to 3/8 while running.
    cfg_pulses = 8'd3; cfg_cycles = 8'd8; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_ps("wait_3_8", 20);
    capture8(pat);
    check("pattern_3_8", pat, 8'hA4);

    // Illegal 5/4 is rejected, ratio stays 3/8.
    cfg_pulses = 8'd5; cfg_cycles = 8'd4; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("illegal_err", cfg_err, 1);
    check("illegal_ready_low", cfg_ready, 0);
    @(negedge clk);
    check("illegal_err_gone", cfg_err, 0);
    check("illegal_ready_back", cfg_ready, 1);
    wait_ps("wait_after_err", 20);
    capture8(pat);
    check("pattern_kept", pat, 8'hA4);

    // Stop sampled at c = 1: busy through c = 7, then idle.
    wait_ps("wait_stop", 20);
    @(negedge clk);
    stop = 1'b1; start = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    check("drain_busy_c2", busy, 1);
    for (int c = 3; c < 8; c++) begin
      @(negedge clk);
      check("drain_busy", busy, 1);
    end
    check("drain_last_en", clk_enable, 1);
    @(negedge clk);
    check("stopped_busy", busy, 0);
    check("stopped_en", clk_enable, 0);
    check("stopped_ps", period_start, 0);

    // Reset mid-period with a pending 1/4 config.
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cfg_pulses = 8'd1; cfg_cycles = 8'd4; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("pending_ready_low", cfg_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("restart_en", clk_enable, i % 2);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int mm;
      @(negedge clk);
      rst       = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, 3) != 0);
      stop      = ($urandom_range(0, 15) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      mm        = $urandom_range(0, 9);
      cfg_cycles = 8'(mm);
      cfg_pulses = 8'($urandom_range(0, mm + 2));
    end

`ifdef RATE_SCHED_STATS_EN
    // P = 0, M = 4 for exactly three periods.
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cfg_pulses = 8'd0; cfg_cycles = 8'd4; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("stats_no_pulse", clk_enable, 0);
      if (i == 8) begin
        stop  = 1'b1;
        start = 1'b0;
      end
    end
    stop = 1'b0;
    @(negedge clk);
    check("stats_idle", busy, 0);
    check("stats_period_count", period_count, 3);
    check("stats_mismatch", pulse_mismatch, 0);
`else
    @(negedge clk);
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
